// File: rtl/uart_sched_pkg.sv
// Shared definitions for the UART APB scheduler: FSM state encodings,
// APB phase encodings, UART register map and status bit positions.
package uart_sched_pkg;

    localparam logic [2:0] ST_CFG_DIV   = 3'd0;
    localparam logic [2:0] ST_CFG_FRAME = 3'd1;
    localparam logic [2:0] ST_ARB       = 3'd2;
    localparam logic [2:0] ST_TX_POLL   = 3'd3;
    localparam logic [2:0] ST_TX_WRITE  = 3'd4;
    localparam logic [2:0] ST_RX_POLL   = 3'd5;

    // Named view of the state encoding, handy in waveforms
    typedef enum logic [2:0] {
        CFG_DIV   = ST_CFG_DIV,
        CFG_FRAME = ST_CFG_FRAME,
        ARB       = ST_ARB,
        TX_POLL   = ST_TX_POLL,
        TX_WRITE  = ST_TX_WRITE,
        RX_POLL   = ST_RX_POLL
    } sched_state_e;

    localparam logic [1:0] PH_IDLE   = 2'd0;
    localparam logic [1:0] PH_SETUP  = 2'd1;
    localparam logic [1:0] PH_ACCESS = 2'd2;

    localparam logic [11:0] UART_ADDR_DIV   = 12'h000;
    localparam logic [11:0] UART_ADDR_FRAME = 12'h004;
    localparam logic [11:0] UART_ADDR_TX    = 12'h008;
    localparam logic [11:0] UART_ADDR_RX    = 12'h00C;

    localparam int TX_BUSY_BIT  = 0;
    localparam int RX_VALID_BIT = 31;

    // Index width that stays legal for a single requester
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin search: first asserted request at or above
// ptr, wrapping around. The pointer register is owned by the parent.
module uart_rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               hit
);

    // Scan NUM_REQ candidates starting at ptr and keep the first hit
    always_comb begin
        int cand;
        cand      = 0;
        grant     = '0;
        grant_idx = '0;
        hit       = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (!hit && req[cand]) begin
                hit         = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_apb_scheduler.sv
// APB3 master sharing one UART between NUM_REQ TX byte requesters and an
// RX byte stream. Programs CLOCK_DIV and FRAME after reset, then alternates
// TX service (poll STATUS, write TX DATA) with RX polling.
// Optional build macro UART_SCHED_STATS_EN adds saturating tx_count/rx_count.
module uart_apb_scheduler
    import uart_sched_pkg::*;
#(
    parameter int          NUM_REQ       = 2,
    parameter logic [31:0] CLOCK_DIV_CFG = 32'd434,
    parameter logic [31:0] FRAME_CFG     = 32'h0000_0008
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 rx_valid,
    output logic [7:0]           rx_data,
    input  logic                 rx_ready,
    output logic                 cfg_done,
    output logic                 m_psel,
    output logic                 m_penable,
    output logic                 m_pwrite,
    output logic [11:0]          m_paddr,
    output logic [31:0]          m_pwdata,
    input  logic [31:0]          m_prdata,
    input  logic                 m_pready,
    input  logic                 m_pslverr,
    output logic                 err
`ifdef UART_SCHED_STATS_EN
    ,
    output logic [15:0]          tx_count,
    output logic [15:0]          rx_count
`endif
);

    localparam int IDX_W = idx_width(NUM_REQ);

    logic [2:0]         state;
    logic [1:0]         phase;
    logic [IDX_W-1:0]   rr_ptr;
    logic               last_rx;
    logic [7:0]         tx_hold;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               hit;
    logic               xfer_done;
    logic               tx_turn;
    logic               take_tx;
    logic               take_rx;
    logic               xfer_req;
    logic [11:0]        xfer_addr;
    logic               xfer_write;
    logic [31:0]        xfer_wdata;

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .hit       (hit)
    );

    // TX is preferred after an RX turn, or whenever RX cannot be polled
    // because a received byte is still waiting for the consumer.
    assign xfer_done = (phase == PH_ACCESS) && m_pready;
    assign tx_turn   = last_rx || rx_valid;
    assign take_tx   = (state == ST_ARB) && hit && tx_turn;
    assign take_rx   = (state == ST_ARB) && !take_tx && !rx_valid;
    assign req_ready = take_tx ? grant : '0;

    // Bus transfer parameters owned by each state
    always_comb begin
        xfer_req   = 1'b1;
        xfer_addr  = '0;
        xfer_write = 1'b0;
        xfer_wdata = '0;
        case (state)
            ST_CFG_DIV: begin
                xfer_addr  = UART_ADDR_DIV;
                xfer_write = 1'b1;
                xfer_wdata = CLOCK_DIV_CFG;
            end
            ST_CFG_FRAME: begin
                xfer_addr  = UART_ADDR_FRAME;
                xfer_write = 1'b1;
                xfer_wdata = FRAME_CFG;
            end
            ST_TX_POLL:  xfer_addr = UART_ADDR_TX;
            ST_TX_WRITE: begin
                xfer_addr  = UART_ADDR_TX;
                xfer_write = 1'b1;
                xfer_wdata = {24'h0, tx_hold};
            end
            ST_RX_POLL:  xfer_addr = UART_ADDR_RX;
            default:     xfer_req = 1'b0;
        endcase
    end

    // APB phase sequencer; the idle phase between transfers guarantees a psel gap
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            phase     <= PH_IDLE;
            m_psel    <= 1'b0;
            m_penable <= 1'b0;
            m_pwrite  <= 1'b0;
            m_paddr   <= '0;
            m_pwdata  <= '0;
        end else begin
            case (phase)
                PH_IDLE: begin
                    if (xfer_req) begin
                        m_psel   <= 1'b1;
                        m_paddr  <= xfer_addr;
                        m_pwrite <= xfer_write;
                        m_pwdata <= xfer_wdata;
                        phase    <= PH_SETUP;
                    end
                end
                PH_SETUP: begin
                    m_penable <= 1'b1;
                    phase     <= PH_ACCESS;
                end
                PH_ACCESS: begin
                    if (m_pready) begin
                        m_psel    <= 1'b0;
                        m_penable <= 1'b0;
                        phase     <= PH_IDLE;
                    end
                end
                default: phase <= PH_IDLE;
            endcase
        end
    end

    // Scheduler FSM, arbitration pointer, RX holding register and error flag
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state    <= ST_CFG_DIV;
            rr_ptr   <= '0;
            last_rx  <= 1'b1;
            tx_hold  <= '0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            cfg_done <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
            if (xfer_done && m_pslverr)
                err <= 1'b1;
            case (state)
                ST_CFG_DIV: if (xfer_done) state <= ST_CFG_FRAME;
                ST_CFG_FRAME: begin
                    if (xfer_done) begin
                        cfg_done <= 1'b1;
                        state    <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (take_tx) begin
                        tx_hold <= req_data[8*int'(grant_idx) +: 8];
                        if (int'(grant_idx) == NUM_REQ - 1)
                            rr_ptr <= '0;
                        else
                            rr_ptr <= grant_idx + 1'b1;
                        state <= ST_TX_POLL;
                    end else if (take_rx) begin
                        state <= ST_RX_POLL;
                    end
                end
                ST_TX_POLL: begin
                    if (xfer_done && !m_prdata[TX_BUSY_BIT])
                        state <= ST_TX_WRITE;
                end
                ST_TX_WRITE: begin
                    if (xfer_done) begin
                        last_rx <= 1'b0;
                        state   <= ST_ARB;
                    end
                end
                ST_RX_POLL: begin
                    if (xfer_done) begin
                        if (m_prdata[RX_VALID_BIT]) begin
                            rx_data  <= m_prdata[7:0];
                            rx_valid <= 1'b1;
                        end
                        last_rx <= 1'b1;
                        state   <= ST_ARB;
                    end
                end
                default: state <= ST_CFG_DIV;
            endcase
        end
    end

`ifdef UART_SCHED_STATS_EN
    // Saturating counts of bytes written to the UART and bytes received
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tx_count <= '0;
            rx_count <= '0;
        end else begin
            if (state == ST_TX_WRITE && xfer_done && tx_count != 16'hFFFF)
                tx_count <= tx_count + 16'd1;
            if (state == ST_RX_POLL && xfer_done && m_prdata[RX_VALID_BIT] && rx_count != 16'hFFFF)
                rx_count <= rx_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/uart_apb_scheduler.md
Name: uart_apb_scheduler

Overview:
- APB3 master that owns one APB3 UART slave and shares its TX path between NUM_REQ byte-stream requesters.
- Out of reset it programs CLOCK_DIV and FRAME, then alternates two jobs:
  - round-robin TX service: poll TX STATUS, write TX DATA.
  - RX polling: read RX DATA/VALID and deliver each valid byte on a single valid/ready output stream.
- Sits between the core-side byte producers and the UART's APB port.
- UART map:
  - 0x00 CLOCK_DIV
  - 0x04 FRAME
  - 0x08 write = TX DATA, read = STATUS (bit0 = busy)
  - 0x0C RX DATA/VALID (bit31 = valid, [7:0] = data); a read pops the byte when valid.

Parameters:
- NUM_REQ, 2, number of TX requesters (1..8).
- CLOCK_DIV_CFG, 434, value written to 0x00 after reset.
- FRAME_CFG, 32'h0000_0008, value written to 0x04 after reset (8N1).

Ports:
- pclk  in  1  clock
- presetn  in  1  async active-low reset
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  8*NUM_REQ  byte for requester i at [8i+7:8i]
- req_ready  out  NUM_REQ  one-hot one-cycle accept pulse
- rx_valid  out  1  received byte valid
- rx_data  out  8  received byte
- rx_ready  in  1  consumer accepts rx_data
- cfg_done  out  1  high once both config writes complete
- err  out  1  sticky; set on any completed transfer with m_pslverr=1
- m_psel, m_penable, m_pwrite  out  1 each  APB3 master controls
- m_paddr  out  12  APB address
- m_pwdata  out  32  APB write data
- m_prdata  in  32  APB read data
- m_pready, m_pslverr  in  1 each  APB completion and error

Behaviour:
- Interface: reset presetn, asynchronous, active-low; clock pclk.
- Reset values:
  - all m_* = 0; req_ready = 0; rx_valid = 0; rx_data = 0; cfg_done = 0; err = 0.
  - RR pointer = 0; state = CFG_DIV.
- APB transfer timing:
  - SETUP cycle: psel=1, penable=0.
  - ACCESS cycles: psel=1, penable=1, held until m_pready=1.
  - Address, pwrite and pwdata are stable through the whole transfer.
  - m_prdata is sampled at the ACCESS cycle where m_pready=1.
  - Transfers are never back-to-back: psel drops for at least one cycle between transfers.
- States: CFG_DIV, CFG_FRAME, ARB, TX_POLL, TX_WRITE, RX_POLL.
  - CFG_DIV: write CLOCK_DIV_CFG to 0x00, then go to CFG_FRAME.
  - CFG_FRAME: write FRAME_CFG to 0x04, set cfg_done, then go to ARB.
  - ARB, TX turn (last_job = RX, or no RX possible):
    - Search req_valid from the RR pointer upward, with wrap-around.
    - On a hit for requester g: assert req_ready[g] for 1 cycle and latch the byte into tx_hold.
    - Set the RR pointer to g+1 mod NUM_REQ, then go to TX_POLL.
  - ARB, RX turn: if rx_valid=0, go to RX_POLL.
  - ARB, fallback: if the preferred job is unavailable, take the other; if neither is available, stay in ARB.
  - TX_POLL: read 0x08.
    - bit0=1: re-poll (same state, after 1 idle cycle).
    - bit0=0: go to TX_WRITE.
  - TX_WRITE: write {24'h0, tx_hold} to 0x08, set last_job = TX, return to ARB.
  - RX_POLL: read 0x0C.
    - bit31=1: rx_data <= m_prdata[7:0]; rx_valid <= 1.
    - Either way, set last_job = RX and return to ARB.
- RX output stream:
  - rx_valid holds until rx_valid & rx_ready.
  - No RX_POLL is issued while rx_valid=1. The UART read pops the byte, so reading while holding would lose data.
- Requester rules:
  - req_data is sampled only in the req_ready cycle.
  - A requester dropping req_valid before it is granted is legal.
- Error handling: m_pslverr=1 on completion sets err. The sequence continues unchanged; there is no retry.
- Fairness:
  - With all requesters valid, each is granted once every NUM_REQ TX turns.
  - TX and RX turns strictly alternate when both are pending.
- Reset mid-transfer: outputs return to reset values asynchronously, and the config sequence restarts.

Optional Feature:
- Macro: UART_SCHED_STATS_EN.
- When defined:
  - Adds output ports tx_count[15:0] and rx_count[15:0]. Both reset to 0.
  - tx_count increments on each completed TX_WRITE.
  - rx_count increments on each rx_valid load.
  - Both counters saturate at 16'hFFFF.
- When undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package uart_sched_pkg:
  - state enum sched_state_e.
  - UART address constants UART_ADDR_DIV/FRAME/TX/RX.
  - bit positions TX_BUSY_BIT=0, RX_VALID_BIT=31.
- One sub-module, uart_rr_arbiter:
  - inputs: NUM_REQ-wide request vector, pointer.
  - outputs: one-hot grant, grant index, any-hit.
  - purely combinational; the pointer register lives in the parent.

Test Plan:
- Reset release with m_pready tied 1 -> writes 0x00=434 then 0x04=0x8, each 2 cycles with a gap; cfg_done=1 after the second write; no other traffic.
- Requester 0 sends 0x41; STATUS returns busy twice, then idle -> one req_ready[0] pulse, three reads of 0x08, then a write of 0x08=0x41.
- Both requesters continuously valid (0xA0 / 0xB0), STATUS idle -> UART writes alternate 0xA0, 0xB0, 0xA0, 0xB0, interleaved with a 0x0C read between each write.
- 0x0C returns 0x8000_0055 with rx_ready=0 for 20 cycles -> rx_valid=1 and rx_data=0x55 held; no 0x0C read issued until the cycle after rx_ready=1.
- m_pready held low 5 cycles during TX_WRITE -> psel, penable, address and data stable throughout; completion with m_pslverr=1 sets err=1 and it stays set.
- With UART_SCHED_STATS_EN, after 3 TX and 2 RX bytes -> tx_count=3, rx_count=2; assert presetn mid-transfer -> all outputs back to reset values and CFG_DIV restarts.
